// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds the fetch buffer entry layout, fetch FSM states and default constants.
package ifetch_pkg;

    localparam int unsigned MEM_WORDS_DEF = 1024;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Word address modulo a power-of-two memory depth.
    function automatic logic [31:0] wrap_pc(
        input logic [31:0] addr,
        input int unsigned words
    );
        return addr & 32'(words - 1);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small power-of-two FIFO of fetch entries with synchronous clear.
// Ports: clk, rst_n (sync, active-low), clr, push/wdata, pop/rdata, count, full, empty.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          push,
    input  fetch_entry_t                  wdata,
    input  logic                          pop,
    output fetch_entry_t                  rdata,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [FIFO_DEPTH];
    fetch_entry_t   mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop & (count_q != '0);
    // A push into a full buffer is legal only when the head leaves this cycle.
    assign do_push = push & ((count_q < CW'(FIFO_DEPTH)) | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational memory port and
// buffers {pc, instr} pairs toward decode over a valid/ready handshake.
// Ports: clk, rst_n (sync, active-low), Read_PC/Instruction (memory side),
// redirect_en/redirect_pc (flush + reload), out_valid/out_ready/out_pc/out_instr
// (decode side), halted.
// Optional halt-on-HALT_WORD support is enabled by defining IFETCH_HALT_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned MEM_WORDS  = MEM_WORDS_DEF,
    parameter int          FIFO_DEPTH = 2
`ifdef IFETCH_HALT_EN
    ,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] Read_PC,
    input  logic [31:0] Instruction,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    fetch_state_t  state_q, state_d;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_wdata;
    fetch_entry_t  fifo_head;

    assign pop  = out_valid & out_ready;
    assign push = (state_q == RUN) & ~redirect_en & (~fifo_full | pop);

    assign fifo_wdata = '{pc: pc_q, instr: Instruction};

    // Redirect doubles as the buffer clear; the FIFO gives clear priority,
    // so a same-cycle pop is dropped along with everything else.
    ifetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (redirect_en),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        pc_d = pc_q;
        if (redirect_en) begin
            pc_d = wrap_pc(redirect_pc, MEM_WORDS);
        end else if (push) begin
            pc_d = wrap_pc(pc_q + 32'd1, MEM_WORDS);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_en) begin
            state_d = RUN;
        end
`ifdef IFETCH_HALT_EN
        else if (push && (Instruction == HALT_WORD)) begin
            state_d = HALT;
        end
`endif
    end

    always_comb begin
        Read_PC   = pc_q;
        out_valid = (fifo_count != '0);
        out_pc    = 32'd0;
        out_instr = 32'd0;
        if (!fifo_empty) begin
            out_pc    = fifo_head.pc;
            out_instr = fifo_head.instr;
        end
`ifdef IFETCH_HALT_EN
        halted = (state_q == HALT);
`else
        halted = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: queue-based reference model plus
// directed literal checks, then randomized redirect/ready/reset traffic.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam int WORDS = 1024;

    logic        clk;
    logic        rst_n;
    logic [31:0] Read_PC;
    logic [31:0] Instruction;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;

    logic [31:0] mem [WORDS];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_entry_t q[$];
    int unsigned  m_pc;
    bit           m_halt;

    ifetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Read_PC     (Read_PC),
        .Instruction (Instruction),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .halted      (halted)
    );

    assign Instruction = mem[Read_PC[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: what the fetch stage must do at one clock edge.
    task automatic model_step();
        bit pop_now;
        bit push_now;
        if (!rst_n) begin
            q.delete();
            m_pc   = 0;
            m_halt = 0;
        end else if (redirect_en) begin
            q.delete();
            m_pc   = redirect_pc % WORDS;
            m_halt = 0;
        end else begin
            pop_now  = (q.size() > 0) && out_ready;
            push_now = !m_halt && ((q.size() < 2) || pop_now);
            if (pop_now) void'(q.pop_front());
            if (push_now) begin
                q.push_back('{pc: m_pc, instr: mem[m_pc]});
`ifdef IFETCH_HALT_EN
                if (mem[m_pc] == 32'hFFFF_FFFF) m_halt = 1;
`endif
                m_pc = (m_pc + 1) % WORDS;
            end
        end
    endtask

    task automatic compare();
        chk("read_pc", Read_PC, m_pc);
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("out_pc", out_pc, q.size() > 0 ? q[0].pc : 32'd0);
        chk("out_instr", out_instr, q.size() > 0 ? q[0].instr : 32'd0);
        chk("halted", 32'(halted), 32'(m_halt));
    endtask

    task automatic step(input logic r, input logic re,
                        input logic [31:0] rp, input logic rdy);
        rst_n       = r;
        redirect_en = re;
        redirect_pc = rp;
        out_ready   = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'hC0DE_0000 + i;
`ifdef IFETCH_HALT_EN
        mem[3]   = 32'hFFFF_FFFF;
        mem[200] = 32'hFFFF_FFFF;
        mem[700] = 32'hFFFF_FFFF;
`endif
        m_pc = 0; m_halt = 0;
        rst_n = 0; redirect_en = 0; redirect_pc = 0; out_ready = 0;
        @(negedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("rst_read_pc", Read_PC, 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        step(1, 0, 0, 1);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_pc", out_pc, 32'd0);
        chk("first_instr", out_instr, 32'hC0DE_0000);
        chk("first_read_pc", Read_PC, 32'd1);
        step(1, 0, 0, 1);
        chk("second_pc", out_pc, 32'd1);
        chk("second_read_pc", Read_PC, 32'd2);

        repeat (5) step(1, 0, 0, 0);
        chk("stall_read_pc", Read_PC, 32'd3);
        chk("stall_head", out_pc, 32'd1);

        step(1, 1, 32'hFFFF_F100, 1);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_read_pc", Read_PC, 32'h100);
        step(1, 0, 0, 1);
        chk("redir_pc", out_pc, 32'h100);
        chk("redir_instr", out_instr, 32'hC0DE_0100);

        step(1, 1, 32'd1023, 1);
        chk("wrap_read_pc", Read_PC, 32'd1023);
        step(1, 0, 0, 1);
        chk("wrap_a", out_pc, 32'd1023);
        step(1, 0, 0, 1);
        chk("wrap_b", out_pc, 32'd0);
        step(1, 0, 0, 1);
        chk("wrap_c", out_pc, 32'd1);

        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_read_pc", Read_PC, 32'd0);

`ifdef IFETCH_HALT_EN
        step(1, 1, 32'd0, 1);
        repeat (6) step(1, 0, 0, 1);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_read_pc", Read_PC, 32'd4);
        step(1, 1, 32'd0, 1);
        chk("halt_clear", 32'(halted), 32'd0);
`endif

        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom(),
                 $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
